// File: rtl/apb_slave_array_if.sv
// APB bus bundle between the bridge (master) and the completer array (slave).
interface apb_slave_array_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned NUM_SLV    = 3
);
    logic [NUM_SLV-1:0]    pselx;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        output pselx, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  pselx, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_slave_array.sv
// APB completer array: one register bank per select line, programmable wait
// states, and error response for bad addresses or non-one-hot selects.
module apb_slave_array #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned NUM_SLV     = 3,
    parameter int unsigned REG_DEPTH   = 8,
    parameter int unsigned WAIT_CYCLES = 0
) (
    input  logic                Hclk,
    input  logic                Hresetn,
    apb_slave_array_if.slave    bus,
    output logic [1:0]          state_out
);

    localparam int unsigned IW = $clog2(REG_DEPTH);
    localparam int unsigned BW = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSetup  = 2'd1,
        StAccess = 2'd2
    } state_e;

    state_e                state_q;
    logic [3:0]            cnt_q;
    logic [DATA_WIDTH-1:0] mem_q [NUM_SLV][REG_DEPTH];

    logic [IW-1:0] idx;
    logic [BW-1:0] bank;
    logic          any_sel;
    logic          multi_sel;
    logic          err;
    logic          done;
    logic          wr_en;

    // Address/select decode and the completing-cycle qualifier.
    always_comb begin
        idx  = bus.paddr[IW+1:2];
        bank = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (bus.pselx[i]) begin
                bank = BW'(i);
            end
        end
        any_sel   = |bus.pselx;
        multi_sel = (bus.pselx & (bus.pselx - NUM_SLV'(1))) != '0;
        err       = (bus.paddr[1:0] != 2'b00) ||
                    (bus.paddr[ADDR_WIDTH-1:IW+2] != '0) ||
                    multi_sel;
        // A dropped select in ACCESS is an abort, so it never completes.
        done      = (state_q == StAccess) && (cnt_q == 4'd0) && any_sel;
        wr_en     = done && bus.pwrite && !err;
    end

    // Response is combinational and zero outside the completing cycle.
    always_comb begin
        bus.pready  = done;
        bus.pslverr = done && err;
        bus.prdata  = (done && !bus.pwrite && !err) ? mem_q[bank][idx] : '0;
    end

    // Transfer FSM with the wait-state counter.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (any_sel && !bus.penable) begin
                        state_q <= StSetup;
                        cnt_q   <= 4'(WAIT_CYCLES);
                    end
                end
                StSetup: begin
                    if (!any_sel) begin
                        state_q <= StIdle;
                    end else if (bus.penable) begin
                        state_q <= StAccess;
                    end
                end
                StAccess: begin
                    if (!any_sel) begin
                        state_q <= StIdle;
                    end else if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else if (!bus.penable) begin
                        // Next setup already on the bus: go straight back to SETUP.
                        state_q <= StSetup;
                        cnt_q   <= 4'(WAIT_CYCLES);
                    end else begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Register banks; only a clean completing write updates storage.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            for (int b = 0; b < NUM_SLV; b++) begin
                for (int w = 0; w < REG_DEPTH; w++) begin
                    mem_q[b][w] <= '0;
                end
            end
        end else if (wr_en) begin
            mem_q[bank][idx] <= bus.pwdata;
        end
    end

    assign state_out = state_q;

endmodule

// File: tb/tb_apb_slave_array.sv
// Bench for apb_slave_array: three instances (0, 3 and 4 wait states) share one
// driver; a scoreboard queue is filled at issue time from an array model and
// drained by a monitor whenever the selected instance raises pready.
module tb_apb_slave_array;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 32;
    localparam int unsigned NS = 3;
    localparam int unsigned RD = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  drv_psel = '0;
    logic        drv_pen = 1'b0;
    logic        drv_wr = 1'b0;
    logic [31:0] drv_addr = '0;
    logic [31:0] drv_data = '0;
    int          cur = 0;

    always #5 clk = ~clk;

    apb_slave_array_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_SLV(NS)) bus0 ();
    apb_slave_array_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_SLV(NS)) bus1 ();
    apb_slave_array_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_SLV(NS)) bus2 ();

    assign bus0.pselx   = (cur == 0) ? drv_psel : 3'b000;
    assign bus1.pselx   = (cur == 1) ? drv_psel : 3'b000;
    assign bus2.pselx   = (cur == 2) ? drv_psel : 3'b000;
    assign bus0.penable = drv_pen;
    assign bus1.penable = drv_pen;
    assign bus2.penable = drv_pen;
    assign bus0.pwrite  = drv_wr;
    assign bus1.pwrite  = drv_wr;
    assign bus2.pwrite  = drv_wr;
    assign bus0.paddr   = drv_addr;
    assign bus1.paddr   = drv_addr;
    assign bus2.paddr   = drv_addr;
    assign bus0.pwdata  = drv_data;
    assign bus1.pwdata  = drv_data;
    assign bus2.pwdata  = drv_data;

    logic [1:0] st0, st1, st2;

    apb_slave_array #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_SLV(NS), .REG_DEPTH(RD),
                      .WAIT_CYCLES(0)) dut0 (
        .Hclk(clk), .Hresetn(rst_n), .bus(bus0), .state_out(st0));
    apb_slave_array #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_SLV(NS), .REG_DEPTH(RD),
                      .WAIT_CYCLES(3)) dut1 (
        .Hclk(clk), .Hresetn(rst_n), .bus(bus1), .state_out(st1));
    apb_slave_array #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_SLV(NS), .REG_DEPTH(RD),
                      .WAIT_CYCLES(4)) dut2 (
        .Hclk(clk), .Hresetn(rst_n), .bus(bus2), .state_out(st2));

    logic        cur_rdy, cur_err;
    logic [31:0] cur_rdata;
    logic [1:0]  cur_st;

    always_comb begin
        case (cur)
            0: begin
                cur_rdy = bus0.pready; cur_err = bus0.pslverr;
                cur_rdata = bus0.prdata; cur_st = st0;
            end
            1: begin
                cur_rdy = bus1.pready; cur_err = bus1.pslverr;
                cur_rdata = bus1.prdata; cur_st = st1;
            end
            default: begin
                cur_rdy = bus2.pready; cur_err = bus2.pslverr;
                cur_rdata = bus2.prdata; cur_st = st2;
            end
        endcase
    end

    // Reference model: plain word arrays per instance and bank.
    logic [31:0] mem [3][NS][RD];

    typedef struct {
        logic        wr;
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sbq[$];
    int   vectors = 0;
    int   miscompares = 0;

    logic [2:0]  b_sel  [8];
    logic        b_wr   [8];
    logic [31:0] b_addr [8];
    logic [31:0] b_data [8];
    int          b_n;

    function automatic int wait_of(input int d);
        return (d == 0) ? 0 : ((d == 1) ? 3 : 4);
    endfunction

    function automatic logic model_err(input logic [2:0] sel, input logic [31:0] addr);
        return ((addr % 4) != 0) || (addr >= 4 * RD) || ($countones(sel) > 1);
    endfunction

    function automatic int bank_of(input logic [2:0] sel);
        for (int i = 0; i < NS; i++) if (sel[i]) return i;
        return 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_model();
        for (int d = 0; d < 3; d++)
            for (int b = 0; b < NS; b++)
                for (int w = 0; w < RD; w++) mem[d][b][w] = '0;
    endtask

    task automatic issue_model(input int d, input logic [2:0] sel, input logic wr,
                               input logic [31:0] addr, input logic [31:0] data,
                               input int lat);
        exp_t e;
        e.wr    = wr;
        e.err   = model_err(sel, addr);
        e.lat   = lat;
        e.rdata = '0;
        if (!e.err) begin
            if (wr) mem[d][bank_of(sel)][addr / 4] = data;
            else    e.rdata = mem[d][bank_of(sel)][addr / 4];
        end
        sbq.push_back(e);
    endtask

    // Burst of b_n transfers with no idle gap between them.
    task automatic run_burst(input int d);
        int  w;
        logic got;
        w   = wait_of(d);
        cur = d;
        @(posedge clk); #1;
        drv_psel = b_sel[0]; drv_pen = 1'b0; drv_wr = b_wr[0];
        drv_addr = b_addr[0]; drv_data = b_data[0];
        for (int k = 0; k < b_n; k++) begin
            @(posedge clk); #1;
            drv_psel = b_sel[k]; drv_pen = 1'b1; drv_wr = b_wr[k];
            drv_addr = b_addr[k]; drv_data = b_data[k];
            issue_model(d, b_sel[k], b_wr[k], b_addr[k], b_data[k], (k == 0) ? w + 3 : w + 2);
            got = 1'b0;
            for (int t = 0; t < 40 && !got; t++) begin
                @(negedge clk);
                got = cur_rdy;
            end
            if (!got) begin
                chk("pready_timeout", 32'(got), 32'd1);
                sbq.delete();
                break;
            end
            if (k < b_n - 1) drv_pen = 1'b0;
        end
        @(posedge clk); #1;
        drv_psel = '0; drv_pen = 1'b0;
    endtask

    task automatic single(input int d, input logic [2:0] sel, input logic wr,
                          input logic [31:0] addr, input logic [31:0] data);
        b_n = 1;
        b_sel[0] = sel; b_wr[0] = wr; b_addr[0] = addr; b_data[0] = data;
        run_burst(d);
    endtask

    // Monitor: pops the scoreboard on every completing cycle.
    int lat_cnt = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            lat_cnt = 0;
        end else begin
            if (drv_psel != 3'b000) lat_cnt++;
            else lat_cnt = 0;
            if (cur_rdy) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_pready", 32'(cur_rdy), 32'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("latency", 32'(lat_cnt), 32'(e.lat));
                    chk("pslverr", 32'(cur_err), 32'(e.err));
                    if (!e.wr) chk("prdata", cur_rdata, e.rdata);
                end
                lat_cnt = 0;
            end else begin
                chk("idle_outputs", {cur_rdata[30:0] | 31'(cur_err), cur_rdata[31]}, 32'd0);
            end
        end
    end

    initial begin
        logic [2:0]  s;
        logic [31:0] a;
        int          r;

        clear_model();
        #12;
        chk("reset_state0", 32'(st0), 32'd0);
        chk("reset_state1", 32'(st1), 32'd0);
        chk("reset_state2", 32'(st2), 32'd0);
        chk("reset_pready", 32'({bus0.pready, bus1.pready, bus2.pready}), 32'd0);
        chk("reset_prdata", bus0.prdata | bus1.prdata | bus2.prdata, 32'd0);
        chk("reset_pslverr", 32'({bus0.pslverr, bus1.pslverr, bus2.pslverr}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic write/read-back with no wait states.
        single(0, 3'b010, 1'b1, 32'h8, 32'hDEADBEEF);
        single(0, 3'b010, 1'b0, 32'h8, 32'h0);

        // Bank isolation at the same word index.
        single(0, 3'b001, 1'b1, 32'h4, 32'h11);
        single(0, 3'b100, 1'b1, 32'h4, 32'h22);
        single(0, 3'b001, 1'b0, 32'h4, 32'h0);
        single(0, 3'b100, 1'b0, 32'h4, 32'h0);
        single(0, 3'b010, 1'b0, 32'h4, 32'h0);

        // Wait states.
        single(1, 3'b001, 1'b0, 32'h0, 32'h0);

        // Error cases followed by read-back of the targets.
        single(0, 3'b001, 1'b0, 32'h40, 32'h0);
        single(0, 3'b001, 1'b1, 32'h40, 32'hBAD0_0001);
        single(0, 3'b001, 1'b0, 32'h6, 32'h0);
        single(0, 3'b001, 1'b1, 32'h6, 32'hBAD0_0002);
        single(0, 3'b011, 1'b1, 32'h8, 32'hBAD0_0003);
        single(0, 3'b001, 1'b0, 32'h8, 32'h0);
        single(0, 3'b010, 1'b0, 32'h8, 32'h0);
        single(0, 3'b001, 1'b0, 32'h4, 32'h0);

        // Back-to-back burst.
        b_n = 4;
        b_sel[0] = 3'b001; b_wr[0] = 1'b1; b_addr[0] = 32'h0;  b_data[0] = 32'hCAFE0001;
        b_sel[1] = 3'b001; b_wr[1] = 1'b0; b_addr[1] = 32'h0;  b_data[1] = 32'h0;
        b_sel[2] = 3'b100; b_wr[2] = 1'b1; b_addr[2] = 32'h1C; b_data[2] = 32'hCAFE0002;
        b_sel[3] = 3'b100; b_wr[3] = 1'b0; b_addr[3] = 32'h1C; b_data[3] = 32'h0;
        run_burst(0);

        // Abort: drop the select after two wait cycles.
        single(2, 3'b001, 1'b1, 32'hC, 32'h5555);
        cur = 2;
        @(posedge clk); #1;
        drv_psel = 3'b001; drv_pen = 1'b0; drv_wr = 1'b1; drv_addr = 32'hC; drv_data = 32'h9999;
        @(posedge clk); #1;
        drv_pen = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort_in_access", 32'(cur_st), 32'd2);
        @(posedge clk); #1;
        drv_psel = '0; drv_pen = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_to_idle", 32'(cur_st), 32'd0);
        single(2, 3'b001, 1'b0, 32'hC, 32'h0);

        // Reset in the middle of a waiting write.
        single(1, 3'b010, 1'b1, 32'h10, 32'h1234);
        cur = 1;
        @(posedge clk); #1;
        drv_psel = 3'b010; drv_pen = 1'b0; drv_wr = 1'b1; drv_addr = 32'h10;
        drv_data = 32'hA5A5A5A5;
        @(posedge clk); #1;
        drv_pen = 1'b1;
        repeat (2) @(negedge clk);
        chk("pre_reset_access", 32'(cur_st), 32'd2);
        #1 rst_n = 1'b0;
        #1;
        chk("reset_mid_state", 32'(cur_st), 32'd0);
        chk("reset_mid_pready", 32'(cur_rdy), 32'd0);
        chk("reset_mid_prdata", cur_rdata, 32'd0);
        drv_psel = '0; drv_pen = 1'b0;
        clear_model();
        sbq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        single(1, 3'b010, 1'b0, 32'h10, 32'h0);
        single(0, 3'b010, 1'b0, 32'h8, 32'h0);

        // Randomised bursts on every instance.
        for (int d = 0; d < 3; d++) begin
            for (int it = 0; it < 40; it++) begin
                b_n = $urandom_range(1, 4);
                for (int k = 0; k < b_n; k++) begin
                    r = $urandom % 8;
                    if (r == 0) begin
                        s = 3'b011 << ($urandom % 2);
                        if ($urandom % 3 == 0) s = 3'b101;
                    end else begin
                        s = 3'b001 << ($urandom % 3);
                    end
                    r = $urandom % 8;
                    a = 32'(($urandom % RD) * 4);
                    if (r == 0) a = a + 32'($urandom_range(1, 3));
                    else if (r == 1) a = 32'($urandom_range(RD, 63) * 4);
                    b_sel[k] = s; b_wr[k] = 1'($urandom % 2); b_addr[k] = a;
                    b_data[k] = $urandom;
                end
                run_burst(d);
            end
        end

        repeat (5) @(posedge clk);
        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
